// File: rtl/arb_pkg.sv
// Shared types and width helpers for the round-robin arbiter.
package arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Wrap-around priority search: first unmasked request at or above ptr.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  input  logic [N_REQ-1:0] excl,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_k;

  // Walk offsets high to low so the smallest offset wins last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    w_sum = '0;
    w_k   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_sum = {1'b0, ptr} + (IW + 1)'(i);
      if (w_sum >= (IW + 1)'(N_REQ))
        w_sum = w_sum - (IW + 1)'(N_REQ);
      w_k = w_sum[IW-1:0];
      if (req[w_k] && !excl[w_k]) begin
        valid = 1'b1;
        idx   = w_k;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered grant and bounded hold time.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 req,
  output logic [N_REQ-1:0]                 gnt,
  output logic [clog2_min1(N_REQ)-1:0]     gnt_id,
  output logic                             gnt_valid,
  output logic                             timeout_pulse
);

  localparam int IW   = clog2_min1(N_REQ);
  localparam int CW   = clog2_min1(MAX_HOLD + 1);
  localparam int HMAX = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

  arb_state_e       r_state;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_own;
  logic [CW-1:0]    r_hold;
  logic [N_REQ-1:0] r_gnt;
  logic [IW-1:0]    r_gnt_id;
  logic             r_gnt_valid;
  logic             r_timeout;

  logic [N_REQ-1:0] w_own_oh;
  logic             w_own_req;
  logic             w_timeout;
  logic             w_hold;
  logic             w_grant;
  logic [N_REQ-1:0] w_excl;
  logic             w_pv;
  logic [IW-1:0]    w_pidx;
  logic [IW-1:0]    w_nptr;

  assign w_own_oh  = N_REQ'(1) << r_own;
  assign w_own_req = req[r_own];
  assign w_excl    = w_timeout ? w_own_oh : '0;
  assign w_nptr    = (w_pidx == IW'(N_REQ - 1)) ? '0 : w_pidx + IW'(1);

  always_comb begin
    w_timeout = 1'b0;
    w_hold    = 1'b0;
    w_grant   = 1'b0;
    if (r_state == ST_OWNED && w_own_req) begin
      w_timeout = (MAX_HOLD > 0) && (r_hold == CW'(HMAX)) &&
                  (|(req & ~w_own_oh));
      w_hold    = !w_timeout;
    end
    w_grant = !w_hold && w_pv;
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .excl  (w_excl),
    .valid (w_pv),
    .idx   (w_pidx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_own       <= '0;
      r_hold      <= '0;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else if (w_hold) begin
      if (r_hold != CW'(HMAX))
        r_hold <= r_hold + CW'(1);
      r_timeout <= 1'b0;
    end else if (w_grant) begin
      r_state     <= ST_OWNED;
      r_own       <= w_pidx;
      r_ptr       <= w_nptr;
      r_hold      <= '0;
      r_gnt       <= N_REQ'(1) << w_pidx;
      r_gnt_id    <= w_pidx;
      r_gnt_valid <= 1'b1;
      r_timeout   <= w_timeout;
    end else begin
      r_state     <= ST_IDLE;
      r_own       <= '0;
      r_hold      <= '0;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end
  end

  assign gnt           = r_gnt;
  assign gnt_id        = r_gnt_id;
  assign gnt_valid     = r_gnt_valid;
  assign timeout_pulse = r_timeout;

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters; legal range 2..16.
REQ-002 Parameter MAX_HOLD, default 16, maximum consecutive grant cycles before forced rotation; 0 means unlimited hold.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req  input  N_REQ  request vector; bit k high means requester k wants the shared resource.
REQ-006 gnt  output  N_REQ  registered grant vector; one-hot or all-zero.
REQ-007 gnt_id  output  max(1,clog2(N_REQ))  registered index of the current owner; 0 when gnt_valid is low.
REQ-008 gnt_valid  output  1  registered; high when any gnt bit is high.
REQ-009 timeout_pulse  output  1  registered; one-cycle pulse on every forced rotation.

Function
REQ-010 The FSM SHALL have two states: IDLE (no owner) and OWNED (owner index own_q held).
REQ-011 A round-robin pointer ptr_q SHALL select the first requester at or above ptr_q, wrapping from N_REQ-1 to 0.
REQ-012 In IDLE with req nonzero, the selected requester SHALL be granted at the next edge, giving one-cycle req-to-gnt latency.
REQ-013 On every new grant to index k, ptr_q SHALL become (k+1) mod N_REQ and hold_cnt SHALL become 0.
REQ-014 In OWNED, while req[own_q] is high and no timeout applies, the grant SHALL be held and hold_cnt SHALL increment, saturating at MAX_HOLD-1.
REQ-015 In OWNED, when req[own_q] is sampled low, the same edge SHALL grant the next requester picked from ptr_q with no bubble cycle, or enter IDLE with gnt all-zero if req is zero.
REQ-016 Timeout: when MAX_HOLD>0, hold_cnt==MAX_HOLD-1, req[own_q] is high, and another req bit is high, the next edge SHALL grant the next requester excluding own_q and SHALL assert timeout_pulse for exactly that cycle.
REQ-017 A sole requester at hold_cnt==MAX_HOLD-1 SHALL keep the grant, and the counter SHALL stay saturated until a competing request appears.
REQ-018 gnt, gnt_id and gnt_valid SHALL always be mutually consistent, and gnt SHALL never have more than one bit set.
REQ-019 Requests that appear and vanish between edges SHALL be ignored; only values sampled at the edge count.
REQ-020 hold_cnt width SHALL be max(1,clog2(MAX_HOLD+1)) and SHALL never wrap.

Reset
REQ-021 Reset low SHALL immediately set state to IDLE, ptr_q to 0, hold_cnt to 0, own_q to 0, gnt to 0, gnt_id to 0, gnt_valid to 0 and timeout_pulse to 0.
REQ-022 Reset asserted mid-grant SHALL drop gnt asynchronously, and arbitration SHALL restart from ptr_q=0 on the first edge after release.

Structure
REQ-023 Package arb_pkg SHALL hold the FSM state enum and the width helper function for index and counter widths.
REQ-024 Sub-module rr_pick (combinational, inputs req, ptr and an exclude mask; outputs valid and index) SHALL implement the wrap-around priority search.

Verification
REQ-025 Reset, then req=4'b0110 -> one edge later gnt=4'b0010, gnt_id=1, gnt_valid=1.
REQ-026 Owner 1 drops its request while req=4'b0100 -> the next edge gives gnt=4'b0100 with no zero-grant cycle; dropping all requests -> gnt=0, IDLE.
REQ-027 MAX_HOLD=4, req=4'b0011 held constant -> owner 0 for 4 cycles, then owner 1 with timeout_pulse high for 1 cycle, then owner 0 again after 4 more cycles.
REQ-028 MAX_HOLD=4, req=4'b1000 only, held 20 cycles -> gnt=4'b1000 throughout with no timeout_pulse.
REQ-029 Reset pulsed low while gnt=4'b0100 -> gnt=0 before the next clock edge; after release, req=4'b1111 -> gnt=4'b0001.
REQ-030 Random req for 10k cycles, N_REQ=3 and 16 -> never more than one gnt bit, gnt_id matches gnt, and no requester held longer than MAX_HOLD cycles while others wait.
